// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit owning the HI/LO registers.
// Latency WIDTH+1 cycles from the accepting edge to the done pulse; one op per WIDTH+1 cycles.
// No queueing: start is ignored while busy; hazard logic stalls on busy; flush aborts in-flight work.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    // op[1] selects divide, op[0] selects signed
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]       state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [1:0]       op_q,      op_d;
    logic [WIDTH-1:0] opnd_q,    opnd_d;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi_q,  acc_hi_d;   // partial product high half / partial remainder
    logic [WIDTH-1:0] acc_lo_q,  acc_lo_d;   // multiplier bits / dividend bits then quotient
    logic             neg_res_q, neg_res_d;  // product or quotient needs negation
    logic             neg_rem_q, neg_rem_d;  // remainder takes the dividend sign
    logic             b_zero_q,  b_zero_d;
    logic [WIDTH-1:0] a_raw_q,   a_raw_d;    // unmodified dividend for the divide-by-zero result
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             dz_q,      dz_d;
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic [WIDTH-1:0] lo_q,      lo_d;

    // Operand conditioning at the accept point
    logic             op_signed;
    logic             op_is_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // Per-iteration datapath
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    // Final sign correction
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes and result signs derived from the incoming request
    always_comb begin
        op_signed = op[0];
        op_is_div = op[1];
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        mag_a     = a_neg ? (~a + 1'b1) : a;
        mag_b     = b_neg ? (~b + 1'b1) : b;
    end

    // One shift-add (multiply) or restoring shift-subtract (divide) step
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift - {1'b0, opnd_q};
    end

    // Sign-corrected results presented in the FINISH cycle
    always_comb begin
        prod_raw = {acc_hi_q, acc_lo_q};
        prod_fix = (op_q[0] && neg_res_q) ? (~prod_raw + 1'b1) : prod_raw;
        quot_fix = (op_q[0] && neg_res_q) ? (~acc_lo_q + 1'b1) : acc_lo_q;
        rem_fix  = (op_q[0] && neg_rem_q) ? (~acc_hi_q + 1'b1) : acc_hi_q;
    end

    // Control FSM and datapath next-state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        a_raw_d   = a_raw_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                // flush outranks start so a squashed instruction never begins
                if (start && !flush) begin
                    state_d   = S_RUN;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    op_d      = op;
                    opnd_d    = op_is_div ? mag_b : mag_a;
                    acc_hi_d  = '0;
                    acc_lo_d  = op_is_div ? mag_a : mag_b;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    b_zero_d  = (b == {WIDTH{1'b0}});
                    a_raw_d   = a;
                end
            end

            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (op_q[1]) begin
                        acc_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi_d = mul_sum[WIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = S_FINISH;
                    end
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!op_q[1]) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                        dz_d = 1'b0;
                    end else if (b_zero_q) begin
                        hi_d = a_raw_q;
                        lo_d = {WIDTH{1'b1}};
                        dz_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                        dz_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            a_raw_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            a_raw_q   <= a_raw_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the pipelined MIPS datapath, sitting beside the ALU in the execute stage and owning the HI/LO architectural registers. It is width-parametrised and performs signed/unsigned multiply and divide over multiple cycles, one bit per cycle, behind a start/busy/done handshake. Results land in HI/LO and hold until the next completed operation. Hazard logic stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand/result width; must be ≥ 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request an operation; accepted only when `busy`=0.
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with `start`.
- `a`, `b`  in  WIDTH each  operands (multiplicand/dividend, multiplier/divisor); sampled with `start`.
- `flush`  in  1  abort any in-flight operation.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: HI/LO just updated.
- `div_zero`  out  1  registered flag, valid with `done`; set when the last divide had `b`=0.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO.

## Operation
- Reset (async): state IDLE; `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, iteration counter=0.
- States: IDLE, RUN, FINISH.
- IDLE: if `start`, latch `op`, the operand magnitudes (two's-complement absolute value for signed ops), and the result sign bits; counter=0; go to RUN. `start` while `busy`=1 is ignored, with no queueing.
- RUN: one iteration per cycle for exactly WIDTH cycles.
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, producing one quotient bit per cycle.
  - After the WIDTH-th iteration go to FINISH.
- FINISH (one cycle): apply sign correction, write HI/LO, go to IDLE.
  - Multiply: {hi,lo} = product; negated if sign(a)^sign(b) for MULT.
  - Divide: lo = quotient, hi = remainder. DIV: quotient sign = sign(a)^sign(b), remainder sign = sign(a).
  - Divide with b=0: hi = a (unmodified), lo = all ones, `div_zero`=1. Multiply and valid divides clear `div_zero`.
  - Signed DIV of most-negative by −1: lo = most-negative, hi = 0 (natural wrap).
- `flush` in RUN or FINISH: return to IDLE next edge; HI/LO and `div_zero` unchanged; no `done`. `flush` in IDLE is a no-op. `flush` and `start` together in IDLE: `flush` wins, nothing starts.

## Timing
- Start accepted at edge E0; `busy`=1 from E0 until edge E0+WIDTH+1.
- At edge E0+WIDTH+1: HI/LO/`div_zero` updated, `done`=1 for one cycle, `busy`=0.
- Latency: WIDTH+1 cycles from start edge to `done`; throughput is one op per WIDTH+1 cycles.
- `start` asserted in the `done` cycle is accepted (back-to-back); `done` then deasserts next cycle while `busy` rises.
- Operands may change after E0 without effect.
- HI/LO are stable at all times except the single update edge.
- Async `reset` mid-operation forces the reset values immediately; no partial HI/LO write.

## Test plan
- MULT, WIDTH=32, a=−3 (0xFFFFFFFD), b=7 -> after 33 cycles `done`; hi=0xFFFFFFFF, lo=0xFFFFFFEB; `busy` high exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=−7, b=2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Then DIV a=0x80000000, b=−1 -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF, `div_zero`=1. Then MULTU 2×3 -> hi=0, lo=6, `div_zero`=0.
- Start MULTU 5×5; pulse `flush` at cycle 10 -> no `done`, HI/LO keep prior values. Second `start` while `busy` ignored. `start` in the `done` cycle accepted.
- WIDTH=8 instance: MULT a=0x80, b=0x80 -> hi=0x40, lo=0x00 after 9 cycles. Assert `reset` mid-RUN -> all outputs 0 immediately.
